// File: rtl/yarp_pkg.sv
// yarp_pkg: shared types and constants for the YARP register file
package yarp_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] xlen_t;
  localparam int unsigned REG_ZERO = '0;
endpackage

// File: rtl/yarp_regfile_sb.sv
// yarp_regfile_sb: per-register busy bits, set by decode alloc, cleared by write-back
//   clk, reset      clock, synchronous active-high reset
//   wr_en_i/addr_i  write-back ports; an enabled write clears busy of its address
//   alloc_en_i/addr alloc from decode; sets busy, overriding a same-cycle clear
//   busy_o          registered busy vector, bit 0 always 0
module yarp_regfile_sb import yarp_pkg::*; #(
  parameter int NUM_REGS = 32,
  parameter int NUM_WR = 2,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]  wr_addr_i,
  input  logic                       alloc_en_i,
  input  logic [AW-1:0]              alloc_addr_i,
  output logic [NUM_REGS-1:0]        busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d, clr;
  always_comb begin
    clr = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_en_i[p]) clr[wr_addr_i[p]] = 1'b1;
    busy_d = busy_q & ~clr;
    if (alloc_en_i) busy_d[alloc_addr_i] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end
  always_ff @(posedge clk) busy_q <= reset ? '0 : busy_d;
  assign busy_o = busy_q;
endmodule

// File: rtl/yarp_regfile_mp.sv
// yarp_regfile_mp: multi-port register file with write bypass and busy scoreboard
//   clk, reset      clock, synchronous active-high reset
//   rs_addr_i       read addresses; rs_data_o/rs_busy_o are combinational per port
//   wr_en_i/addr/data  write-back ports, highest enabled port wins on collision
//   alloc_en_i/addr destination allocation from decode
//   any_busy_o      OR of registered busy bits
module yarp_regfile_mp import yarp_pkg::*; #(
  parameter int XLEN = yarp_pkg::XLEN,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_RD-1:0][AW-1:0]   rs_addr_i,
  output logic [NUM_RD-1:0][XLEN-1:0] rs_data_o,
  output logic [NUM_RD-1:0]           rs_busy_o,
  input  logic [NUM_WR-1:0]           wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0] wr_data_i,
  input  logic                        alloc_en_i,
  input  logic [AW-1:0]               alloc_addr_i,
  output logic                        any_busy_o
);
  logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
  logic [NUM_REGS-1:0] busy;
  // later ports overwrite earlier ones in the loop, so the highest port index wins
  always_ff @(posedge clk)
    if (reset) regs_q <= '0;
    else
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en_i[p] && wr_addr_i[p] != AW'(REG_ZERO)) regs_q[wr_addr_i[p]] <= wr_data_i[p];
  yarp_regfile_sb #(.NUM_REGS(NUM_REGS), .NUM_WR(NUM_WR)) u_sb (
    .clk(clk),
    .reset(reset),
    .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i),
    .alloc_en_i(alloc_en_i),
    .alloc_addr_i(alloc_addr_i),
    .busy_o(busy)
  );
  assign any_busy_o = |busy;
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic hit, alloc_hit;
    logic [XLEN-1:0] byp;
    always_comb begin
      hit = 1'b0;
      byp = regs_q[rs_addr_i[r]];
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en_i[p] && wr_addr_i[p] == rs_addr_i[r] && rs_addr_i[r] != AW'(REG_ZERO)) begin
          hit = 1'b1;
          byp = wr_data_i[p];
        end
    end
    assign alloc_hit = alloc_en_i && alloc_addr_i == rs_addr_i[r];
    assign rs_data_o[r] = BYPASS ? byp : regs_q[rs_addr_i[r]];
    // a same-cycle completing write hides busy unless a new producer is allocated at once
    assign rs_busy_o[r] = busy[rs_addr_i[r]] & ~(BYPASS && hit && !alloc_hit);
  end
endmodule
